register_bank: RTL and testbench
================================

Name: register_bank

Overview:
Parametrised multi-register bank for the 8-bit CPU datapath. It generalises the single clock-enabled, clearable 8-bit register to DEPTH registers of WIDTH bits. It has one write port with in-place operation modes (load, increment, decrement, shift-left) and two independent combinational read ports. Registered carry and zero flags from the last write feed the control unit. It replaces the discrete A/B/temp registers and the program-counter-style counters.

Parameters:
WIDTH, 8, bits per register (>= 2)
DEPTH, 4, number of registers (>= 2; need not be a power of two)
ADDR_WIDTH, $clog2(DEPTH), address width (derived; do not override)
BYPASS, 1, 1 = read ports forward the value being written this cycle; 0 = read ports show stored value only
ZERO_REG, 0, 1 = register 0 reads as constant 0 and ignores writes

Ports:
clock  input  1  system clock; all state updates on rising edge
clear  input  1  synchronous active-high reset
write_enable  input  1  perform write_op on write_address this edge
write_address  input  ADDR_WIDTH  target register
write_op  input  2  00 LOAD, 01 INC, 10 DEC, 11 SHL
write_data  input  WIDTH  load value; bit 0 is the SHL fill bit
read_address_a  input  ADDR_WIDTH  read port A select
read_data_a  output  WIDTH  read port A data (combinational)
read_address_b  input  ADDR_WIDTH  read port B select
read_data_b  output  WIDTH  read port B data (combinational)
carry_out  output  1  registered carry/borrow/shift-out of last accepted write
zero_out  output  1  registered "last accepted write result == 0"

Behaviour:
- Reset: clock is the single clock, and clear is synchronous and active-high. When clear is 1 at a rising edge, all registers go to 0, carry_out goes to 0 and zero_out goes to 0. clear has priority over write_enable. Read outputs then reflect the zeroed registers.
- Write accepted: write_enable = 1, clear = 0, write_address < DEPTH, and not (ZERO_REG = 1 and write_address = 0). When accepted, the result is R and the old value is Q:
  - LOAD: R = write_data; carry_out <= 0.
  - INC: R = Q + 1 mod 2^WIDTH; carry_out <= 1 only when Q was all ones (wrap to 0).
  - DEC: R = Q - 1 mod 2^WIDTH; carry_out <= 1 only when Q was 0 (borrow, wrap to all ones).
  - SHL: R = {Q[WIDTH-2:0], write_data[0]}; carry_out <= Q[WIDTH-1].
  - In all cases the register takes R and zero_out <= (R == 0). Latency is 1 edge.
- Write not accepted (enable low, out-of-range address, or protected reg 0): all registers, carry_out and zero_out hold.
- Reads are combinational with no edge latency.
  - If the address is >= DEPTH, data is 0.
  - If ZERO_REG = 1 and the address is 0, data is 0.
  - If BYPASS = 1 and a write is accepted this cycle to the same address, data is R, the next-state value.
  - Otherwise data is the stored value.
  - Both ports may select the same register, and both see identical data.
  - The bypass path depends only on stored state and write inputs, never on read outputs, so no combinational loop exists.
- Simultaneous events:
  - clear together with write_enable: the clear wins and nothing is written.
  - While clear = 1, bypass is suppressed; read data shows the stored values until the edge.
- Only one register changes per edge. Other registers are untouched by any op.

Test Plan:
- Reset: write 8'hA5 to r1, then clear = 1 with write_enable = 1, LOAD 8'h3C to r1, for one edge -> r1 = 8'h00, carry_out = 0, zero_out = 0; r1 is not 8'h3C.
- Load/read: LOAD r2 = 8'h5A and r3 = 8'hC3 on consecutive edges; read_address_a = 2, read_address_b = 3 -> read_data_a = 8'h5A, read_data_b = 8'hC3, zero_out = 0, carry_out = 0.
- Wrap: LOAD r1 = 8'hFF, then INC r1 -> r1 = 8'h00, carry_out = 1, zero_out = 1. Then DEC r1 -> r1 = 8'hFF, carry_out = 1, zero_out = 0. Then DEC r1 -> 8'hFE, carry_out = 0.
- Shift: LOAD r0 = 8'b1000_0001, then SHL with write_data[0] = 1 -> r0 = 8'b0000_0011, carry_out = 1. Then SHL with fill 0 -> 8'b0000_0110, carry_out = 0.
- Bypass: BYPASS = 1, r2 = 8'h10, INC r2 with read_address_a = 2 -> read_data_a = 8'h11 before the edge. With BYPASS = 0, read_data_a = 8'h10 before the edge and 8'h11 after it.
- Protection/range: ZERO_REG = 1, LOAD r0 = 8'h77 -> read r0 = 8'h00 and flags unchanged. With DEPTH = 3, a write to address 3 is ignored and a read of address 3 returns 8'h00.

Source files
------------

// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH register file for the 8-bit CPU datapath.
// It has one write port that can LOAD, INC, DEC or SHL the addressed register
// in place, and two independent combinational read ports. The carry and zero
// flags of the last accepted write are held in registers.
module register_bank #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [1:0]            write_op,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [ADDR_WIDTH-1:0] read_address_a,
  output logic [WIDTH-1:0]      read_data_a,
  input  logic [ADDR_WIDTH-1:0] read_address_b,
  output logic [WIDTH-1:0]      read_data_b,
  output logic                  carry_out,
  output logic                  zero_out
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // One extra bit, so that DEPTH == 2**ADDR_WIDTH still compares correctly
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];

  logic             write_accept;
  logic [WIDTH-1:0] old_value;
  logic [WIDTH-1:0] write_value;
  logic             write_carry;

  // An address names a real register only if it is below DEPTH (DEPTH need not be 2**N)
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < DEPTH_LIMIT);
  endfunction

  // Readable and writable: in range, and not the hard-wired zero register
  function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] addr);
    return addr_in_range(addr) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  // Result of an in-place op: {carry, new value}. The carry means wrap for INC,
  // borrow for DEC and the shifted-out MSB for SHL. LOAD clears the carry.
  function automatic logic [WIDTH:0] op_result(input logic [WIDTH-1:0] q,
                                               input logic [1:0]       op,
                                               input logic [WIDTH-1:0] data);
    logic [WIDTH:0] res;
    case (op)
      OP_LOAD: res = {1'b0, data};
      OP_INC:  res = {(&q), q + ONE};
      OP_DEC:  res = {~(|q), q - ONE};
      OP_SHL:  res = {q[WIDTH-1], q[WIDTH-2:0], data[0]};
      default: res = {1'b0, data};
    endcase
    return res;
  endfunction

  // Decide whether this edge performs a write, and compute its next-state value
  always_comb begin
    write_accept = write_enable && !clear && addr_live(write_address);
    old_value    = '0;
    if (addr_in_range(write_address)) begin
      old_value = regs[write_address];
    end
    {write_carry, write_value} = op_result(old_value, write_op, write_data);
  end

  // Storage and flags: clear zeroes everything, and an accepted write updates
  // only the addressed register
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
    end else if (write_accept) begin
      regs[write_address] <= write_value;
      carry_out           <= write_carry;
      zero_out            <= (write_value == '0);
    end
  end

  // Read port A: dead addresses read 0; optionally forward the value being written
  always_comb begin
    read_data_a = '0;
    if (addr_live(read_address_a)) begin
      if ((BYPASS != 0) && write_accept && (read_address_a == write_address)) begin
        read_data_a = write_value;
      end else begin
        read_data_a = regs[read_address_a];
      end
    end
  end

  // Read port B: identical selection rules to port A
  always_comb begin
    read_data_b = '0;
    if (addr_live(read_address_b)) begin
      if ((BYPASS != 0) && write_accept && (read_address_b == write_address)) begin
        read_data_b = write_value;
      end else begin
        read_data_b = regs[read_address_b];
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank. Two banks share the same inputs:
// bank0 uses the defaults (DEPTH 4, bypass on, no zero register), and
// bank1 has DEPTH 3, bypass off and a zero register. A driver applies one
// operation per cycle and queues the expected outputs from an array model.
// A monitor pops each entry and compares it at the falling edge.
module tb_register_bank;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       write_enable = 1'b0;
  logic [1:0] write_address = '0;
  logic [1:0] write_op = '0;
  logic [7:0] write_data = '0;
  logic [1:0] read_address_a = '0;
  logic [1:0] read_address_b = '0;

  logic [7:0] rda0, rdb0, rda1, rdb1;
  logic       c0, z0, c1, z1;

  always #5 clock = ~clock;

  register_bank #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .ZERO_REG(0)) u_bank0 (
    .clock(clock), .clear(clear), .write_enable(write_enable),
    .write_address(write_address), .write_op(write_op), .write_data(write_data),
    .read_address_a(read_address_a), .read_data_a(rda0),
    .read_address_b(read_address_b), .read_data_b(rdb0),
    .carry_out(c0), .zero_out(z0)
  );

  register_bank #(.WIDTH(8), .DEPTH(3), .BYPASS(0), .ZERO_REG(1)) u_bank1 (
    .clock(clock), .clear(clear), .write_enable(write_enable),
    .write_address(write_address), .write_op(write_op), .write_data(write_data),
    .read_address_a(read_address_a), .read_data_a(rda1),
    .read_address_b(read_address_b), .read_data_b(rdb1),
    .carry_out(c1), .zero_out(z1)
  );

  typedef struct {
    int         id;
    logic [7:0] a0, b0, a1, b1;
    logic       c0, z0, c1, z1;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int step_id = 0;

  // Model state: plain integer register contents and flags
  int m0 [4];
  int m1 [3];
  bit fc0, fz0, fc1, fz1;

  function automatic void apply(input int q, input logic [1:0] op, input logic [7:0] wd,
                                output int r, output bit c);
    case (op)
      2'd0:    begin r = int'(wd);                 c = 1'b0;       end
      2'd1:    begin r = (q + 1) % 256;            c = (q == 255); end
      2'd2:    begin r = (q + 255) % 256;          c = (q == 0);   end
      default: begin r = (q * 2) % 256 + int'(wd[0]); c = (q >= 128); end
    endcase
  endfunction

  function automatic int read0(input int ra, input bit acc, input int wa, input int r);
    if (acc && ra == wa) return r;
    return m0[ra];
  endfunction

  function automatic int read1(input int ra);
    if (ra == 0 || ra >= 3) return 0;
    return m1[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m0[i] = 0;
    for (int i = 0; i < 3; i++) m1[i] = 0;
    fc0 = 0; fz0 = 0; fc1 = 0; fz1 = 0;
  endtask

  // Drive one cycle of stimulus, queue the expected pre-edge view, then advance the model
  task automatic step(input bit clr, input bit we, input logic [1:0] wa, input logic [1:0] op,
                      input logic [7:0] wd, input logic [1:0] ra, input logic [1:0] rb);
    exp_t e;
    int   q1, r0, r1;
    bit   cy0, cy1, acc0, acc1;
    @(posedge clock);
    #1;
    clear = clr; write_enable = we; write_address = wa; write_op = op;
    write_data = wd; read_address_a = ra; read_address_b = rb;

    acc0 = we && !clr;
    acc1 = we && !clr && (wa != 0) && (wa < 3);
    q1   = (wa < 3) ? m1[wa] : 0;
    apply(m0[wa], op, wd, r0, cy0);
    apply(q1, op, wd, r1, cy1);

    step_id++;
    e.id = step_id;
    e.a0 = 8'(read0(int'(ra), acc0, int'(wa), r0));
    e.b0 = 8'(read0(int'(rb), acc0, int'(wa), r0));
    e.a1 = 8'(read1(int'(ra)));
    e.b1 = 8'(read1(int'(rb)));
    e.c0 = fc0; e.z0 = fz0; e.c1 = fc1; e.z1 = fz1;
    sb.push_back(e);

    if (clr) begin
      model_reset();
    end else begin
      if (acc0) begin m0[wa] = r0; fc0 = cy0; fz0 = (r0 == 0); end
      if (acc1) begin m1[wa] = r1; fc1 = cy1; fz1 = (r1 == 0); end
    end
  endtask

  task automatic check(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("bank0_rd_a", e.id, rda0, e.a0);
        check("bank0_rd_b", e.id, rdb0, e.b0);
        check("bank0_carry", e.id, {7'd0, c0}, {7'd0, e.c0});
        check("bank0_zero", e.id, {7'd0, z0}, {7'd0, e.z0});
        check("bank1_rd_a", e.id, rda1, e.a1);
        check("bank1_rd_b", e.id, rdb1, e.b1);
        check("bank1_carry", e.id, {7'd0, c1}, {7'd0, e.c1});
        check("bank1_zero", e.id, {7'd0, z1}, {7'd0, e.z1});
      end
    end
  end

  // Driver: reset, directed scenarios, then randomized traffic
  initial begin
    logic [7:0] wd;
    repeat (2) @(posedge clock);
    model_reset();

    // Reset state, then clear beating a simultaneous write
    step(0, 0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd1);
    step(0, 1, 2'd1, 2'd0, 8'hA5, 2'd1, 2'd1);
    step(1, 1, 2'd1, 2'd0, 8'h3C, 2'd1, 2'd1);
    step(0, 0, 2'd1, 2'd0, 8'h00, 2'd1, 2'd2);
    // Load and dual read
    step(0, 1, 2'd2, 2'd0, 8'h5A, 2'd2, 2'd3);
    step(0, 1, 2'd3, 2'd0, 8'hC3, 2'd2, 2'd3);
    step(0, 0, 2'd0, 2'd0, 8'h00, 2'd2, 2'd3);
    // Wrap on INC and DEC
    step(0, 1, 2'd1, 2'd0, 8'hFF, 2'd1, 2'd1);
    step(0, 1, 2'd1, 2'd1, 8'h00, 2'd1, 2'd2);
    step(0, 1, 2'd1, 2'd2, 8'h00, 2'd1, 2'd2);
    step(0, 1, 2'd1, 2'd2, 8'h00, 2'd1, 2'd2);
    step(0, 0, 2'd1, 2'd0, 8'h00, 2'd1, 2'd1);
    // Shift left with fill bit
    step(0, 1, 2'd0, 2'd0, 8'h81, 2'd0, 2'd0);
    step(0, 1, 2'd0, 2'd3, 8'h01, 2'd0, 2'd1);
    step(0, 1, 2'd0, 2'd3, 8'h00, 2'd0, 2'd1);
    step(0, 0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd1);
    // Bypass vs stored view around an INC
    step(0, 1, 2'd2, 2'd0, 8'h10, 2'd2, 2'd1);
    step(0, 1, 2'd2, 2'd1, 8'h00, 2'd2, 2'd2);
    step(0, 0, 2'd2, 2'd0, 8'h00, 2'd2, 2'd2);
    // Clear with a write pending: bypass suppressed
    step(1, 1, 2'd2, 2'd1, 8'h00, 2'd2, 2'd2);
    step(0, 0, 2'd2, 2'd0, 8'h00, 2'd2, 2'd2);
    // Zero register protection and out-of-range address
    step(0, 1, 2'd1, 2'd0, 8'h80, 2'd1, 2'd0);
    step(0, 1, 2'd0, 2'd0, 8'h77, 2'd0, 2'd1);
    step(0, 0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd1);
    step(0, 1, 2'd3, 2'd0, 8'h55, 2'd3, 2'd3);
    step(0, 0, 2'd3, 2'd0, 8'h00, 2'd3, 2'd0);

    // Randomized traffic with extra weight on the wrap values
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       wd = 8'hFF;
        1:       wd = 8'h00;
        default: wd = 8'($urandom);
      endcase
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), wd,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
